fmap1_buffer: RTL
=================

Name: fmap1_buffer

Overview:
- Downstream stage of the conv1 layer (5x5 conv, ReLU, 2x2 maxpool).
- Captures its channel-serial pooled output: CO channels, each O_SIZE x O_SIZE, raster order, one word per i_en.
- Once the full frame is stored, it replays the frame pixel-parallel: one beat carries all CO channel values of one pixel, over a valid/ready handshake, to feed the CI=4 conv2 stage.
- Holds exactly one frame; no ping-pong.

Parameters:
BW, 16, data word width (signed)
O_SIZE, 12, pooled map side length
CO, 4, channels per frame
DEPTH, 144, O_SIZE*O_SIZE words per channel bank (derived)
ADDR_W, 8, clog2(DEPTH) (derived)

Ports:
clk  in  1  clock, all logic on rising edge
global_rst_n  in  1  asynchronous active-low reset
rst_processEnd  in  1  synchronous clear; same effect as reset, except bank contents are not cleared
i_data  in  BW  signed pooled result from conv1
i_en  in  1  i_data valid this cycle
i_ch_end  in  1  upstream end-of-channel pulse (checked only)
i_allch_end  in  1  upstream all-channels-done pulse (checked only)
o_data  out  CO*BW  {ch CO-1 ... ch0}; ch0 in the LSBs
o_valid  out  1  o_data valid
i_ready  in  1  consumer accepts the beat when o_valid && i_ready
o_last  out  1  marks the final beat (pixel DEPTH-1)
o_full  out  1  frame stored, drain not yet finished
o_err  out  1  sticky protocol error

Behaviour:
- Reset (async or rst_processEnd):
  - State goes to FILL; pix and ch counters go to 0.
  - o_valid, o_last, o_full and o_err go to 0; o_data goes to 0.
- Storage: CO banks of DEPTH x BW, synchronous write and synchronous 1-cycle read. Bank contents are not reset.
- FILL state:
  - On i_en, write i_data to bank[ch][pix], then increment pix.
  - When pix==DEPTH-1 and i_en, pix wraps to 0 and ch increments.
  - On the write with ch==CO-1 and pix==DEPTH-1, the next state is FULL and o_full=1 from the next cycle.
- Checks (violations set o_err sticky; data path unaffected):
  - i_ch_end must coincide with the cycle that wraps pix, or with the cycle after it.
  - i_allch_end seen in FILL with ch<CO-1 is an error.
- FULL state: one cycle to issue a read at pix=0. Next state is DRAIN.
- DRAIN state:
  - o_valid rises 2 cycles after FULL was entered.
  - Beat k: o_data = {bank[CO-1][k], ..., bank[0][k]}; o_last=1 when k==DEPTH-1.
  - On handshake, advance k. Throughput is 1 beat/cycle while i_ready stays high, using a prefetch register (2-entry skid).
  - While o_valid && !i_ready, o_data and o_last stay stable.
- Drain end:
  - On the handshake of the o_last beat, o_valid and o_full go to 0 in the next cycle.
  - State goes to FILL with counters at 0. The buffer can accept a new frame from that next cycle.
- i_en outside FILL: write dropped, o_err set.
- i_en on the same cycle as the final-beat handshake: dropped, o_err set. FILL starts only on the next cycle.
- rst_processEnd mid-DRAIN: o_valid drops on the next cycle with no further beats. Bank contents are not cleared.
- Reset priority: global_rst_n > rst_processEnd > all else.

Decomposition:
- Shared package: BW, O_SIZE, CO, DEPTH, ADDR_W, and the state encoding (FILL/FULL/DRAIN). These are shared with conv1/conv2.
- One sub-module: fmap_bank, a single-port BRAM with registered read, instantiated CO times. Chosen so synthesis infers BRAM.

Test Plan:
1. Reset, then write 576 words with value = ch*1000+pix, i_ready=1 → o_full=1 after word 575. First beat is {3000,2000,1000,0}. Beat 143 is {3143,2143,1143,143} with o_last=1. 144 consecutive beats, then o_valid=0.
2. Same frame, i_ready toggling 1,0,0,1 → o_data stays stable during stalls. All 144 beats in order; none lost or duplicated.
3. i_en asserted during DRAIN with data 0x7FFF → o_err=1. Drained data is unchanged from test 1.
4. i_ch_end pulsed at pix=70 of ch1 → o_err=1. Fill continues and o_full still rises after 576 writes.
5. rst_processEnd at DRAIN beat 50 → o_valid=0 next cycle. A fresh 576-word frame then drains correctly starting at beat 0.
6. Back-to-back frames: frame B's first i_en one cycle after frame A's o_last handshake → accepted, o_err=0. Frame B drains correctly with negative values (-5 → 0xFFFB).

Source files
------------

// File: rtl/fmap1_pkg.sv
// Shared parameters and state encoding for the conv1 -> conv2 feature-map buffer.
package fmap1_pkg;

  localparam int BW     = 16;
  localparam int O_SIZE = 12;
  localparam int CO     = 4;
  localparam int DEPTH  = O_SIZE * O_SIZE;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CH_W   = (CO > 1) ? $clog2(CO) : 1;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_FULL  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/fmap1_buffer_bank.sv
// One channel bank: single-port RAM with registered read, written so synthesis maps it to block RAM.
module fmap_bank
  import fmap1_pkg::*;
#(
  parameter int W  = BW,
  parameter int D  = DEPTH,
  parameter int AW = ADDR_W
) (
  input  logic          clk,
  input  logic          en_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [D];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) mem_q[addr_i] <= wdata_i;
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fmap1_buffer.sv
// Captures one channel-serial pooled frame from conv1 and replays it pixel-parallel to conv2.
//   state    | meaning
//   ST_FILL  | accepting i_en words, ch-major then raster pixel order
//   ST_FULL  | frame stored; issue the first bank read
//   ST_DRAIN | streaming one pixel (all channels) per handshake
module fmap1_buffer
  import fmap1_pkg::*;
(
  input  logic                 clk,
  input  logic                 global_rst_n,
  input  logic                 rst_processEnd,
  input  logic signed [BW-1:0] i_data,
  input  logic                 i_en,
  input  logic                 i_ch_end,
  input  logic                 i_allch_end,
  output logic [CO*BW-1:0]     o_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_last,
  output logic                 o_full,
  output logic                 o_err
);

  localparam int PIX_W = ADDR_W + 1;
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(DEPTH - 1);
  localparam logic [PIX_W-1:0] PIX_END  = PIX_W'(DEPTH);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CO - 1);

  state_e             state_q, state_d;
  logic [PIX_W-1:0]   pix_q, pix_d;
  logic [CH_W-1:0]    ch_q, ch_d;
  logic               wrap_q, wrap_d;
  logic               rd_pend_q, rd_pend_d;
  logic               rd_last_q, rd_last_d;
  logic [CO*BW-1:0]   out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  logic               out_last_q, out_last_d;
  logic [CO*BW-1:0]   sk_data_q, sk_data_d;
  logic               sk_valid_q, sk_valid_d;
  logic               sk_last_q, sk_last_d;
  logic               err_q, err_d;

  logic               fill_wr, wrap, pop, rd_issue;
  logic [2:0]         fill_lvl;
  logic [CO*BW-1:0]   rd_word;

  assign fill_wr  = (state_q == ST_FILL) && i_en;
  assign wrap     = fill_wr && (pix_q == PIX_LAST);
  assign pop      = out_valid_q && i_ready;
  // Occupancy of output + skid registers once this cycle's pop and in-flight read settle.
  assign fill_lvl = {2'b00, out_valid_q} + {2'b00, sk_valid_q} + {2'b00, rd_pend_q} - {2'b00, pop};
  assign rd_issue = (state_q != ST_FILL) && (pix_q < PIX_END) && (fill_lvl < 3'd2) && !rst_processEnd;

  for (genvar g = 0; g < CO; g++) begin : g_bank
    logic we_g;
    assign we_g = fill_wr && (ch_q == CH_W'(g)) && !rst_processEnd;
    fmap_bank u_bank (
      .clk     (clk),
      .en_i    (we_g | rd_issue),
      .we_i    (we_g),
      .addr_i  (pix_q[ADDR_W-1:0]),
      .wdata_i (i_data),
      .rdata_o (rd_word[g*BW +: BW])
    );
  end

  always_comb begin
    state_d     = state_q;
    pix_d       = pix_q;
    ch_d        = ch_q;
    wrap_d      = wrap;
    rd_pend_d   = rd_issue;
    rd_last_d   = rd_issue && (pix_q == PIX_LAST);
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    sk_data_d   = sk_data_q;
    sk_valid_d  = sk_valid_q;
    sk_last_d   = sk_last_q;
    err_d       = err_q;

    unique case (state_q)
      ST_FILL: begin
        if (fill_wr) begin
          if (wrap) begin
            pix_d = '0;
            ch_d  = (ch_q == CH_LAST) ? '0 : ch_q + 1'b1;
            if (ch_q == CH_LAST) state_d = ST_FULL;
          end else begin
            pix_d = pix_q + 1'b1;
          end
        end
      end
      ST_FULL:  state_d = ST_DRAIN;
      ST_DRAIN: begin end
      default:  state_d = ST_FILL;
    endcase

    if (rd_issue) pix_d = pix_q + 1'b1;

    if ((state_q == ST_DRAIN) && pop && out_last_q) begin
      state_d = ST_FILL;
      pix_d   = '0;
      ch_d    = '0;
    end

    // Landing read data goes to the output register when it frees up, else to the skid.
    if (!out_valid_q || pop) begin
      if (sk_valid_q) begin
        out_data_d  = sk_data_q;
        out_last_d  = sk_last_q;
        out_valid_d = 1'b1;
        sk_valid_d  = rd_pend_q;
        if (rd_pend_q) begin
          sk_data_d = rd_word;
          sk_last_d = rd_last_q;
        end
      end else if (rd_pend_q) begin
        out_data_d  = rd_word;
        out_last_d  = rd_last_q;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
      end
    end else if (rd_pend_q) begin
      sk_data_d  = rd_word;
      sk_last_d  = rd_last_q;
      sk_valid_d = 1'b1;
    end

    err_d = err_q
          | (i_en && (state_q != ST_FILL))
          | (i_allch_end && (state_q == ST_FILL) && (ch_q != CH_LAST))
          | (i_ch_end && !(wrap || wrap_q));

    if (rst_processEnd) begin
      state_d     = ST_FILL;
      pix_d       = '0;
      ch_d        = '0;
      wrap_d      = 1'b0;
      rd_pend_d   = 1'b0;
      rd_last_d   = 1'b0;
      out_data_d  = '0;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      sk_valid_d  = 1'b0;
      sk_last_d   = 1'b0;
      err_d       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n) begin
      state_q     <= ST_FILL;
      pix_q       <= '0;
      ch_q        <= '0;
      wrap_q      <= 1'b0;
      rd_pend_q   <= 1'b0;
      rd_last_q   <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      sk_data_q   <= '0;
      sk_valid_q  <= 1'b0;
      sk_last_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pix_q       <= pix_d;
      ch_q        <= ch_d;
      wrap_q      <= wrap_d;
      rd_pend_q   <= rd_pend_d;
      rd_last_q   <= rd_last_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      sk_data_q   <= sk_data_d;
      sk_valid_q  <= sk_valid_d;
      sk_last_q   <= sk_last_d;
      err_q       <= err_d;
    end
  end

  assign o_data  = out_data_q;
  assign o_valid = out_valid_q;
  assign o_last  = out_last_q;
  assign o_full  = (state_q != ST_FILL);
  assign o_err   = err_q;

endmodule
